uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart_tx byte transmitter between NUM_REQ requesters (board printer, user-input echo, judge/status text).
//  Grants are round-robin and locked per message: once granted, a requester owns the TX until it drops req.
//  Bytes from different requesters therefore never interleave.
//  Sits between the requester modules and uart_tx in the top level; replaces OR-ed wr / priority-muxed din sharing.
// PARAMETERS
//  NUM_REQ         3       number of requesters, 2..8; index 0 has first priority out of reset
//  TIMEOUT_CYCLES  100000  idle cycles before a held grant is revoked (only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous active-high reset
//  req         in   NUM_REQ    per-requester ownership request, held high for a whole message
//  wr          in   NUM_REQ    per-requester byte write strobe (1 cycle per byte)
//  din         in   8*NUM_REQ  per-requester byte; requester i uses din[8*i+:8]
//  grant       out  NUM_REQ    one-hot (or zero) ownership, registered
//  ready       out  NUM_REQ    ready[i] = grant[i] & uart_ready (combinational)
//  uart_wr     out  1          write strobe to uart_tx
//  uart_din    out  8          byte to uart_tx
//  uart_ready  in   1          uart_tx can accept a byte
//  busy        out  1          high while any grant is held
//  drop_err    out  1          1-cycle pulse: a write was discarded
// BEHAVIOUR
//  Reset: grant=0, busy=0, drop_err=0, uart_wr=0, uart_din=0, state=IDLE, rr pointer=0.
//  FSM states: IDLE, OWN, GAP.
//  IDLE: if |req, pick the first set req at or after ptr (cyclic); grant[g]<=1, go to OWN.
//   The grant appears 1 cycle after req is sampled.
//  OWN: uart_wr = wr[g] & uart_ready; uart_din = din[g] (combinational path from requester to uart_tx, 0-cycle latency).
//   When req[g] falls: grant<=0, ptr<=(g+1)%NUM_REQ, go to GAP.
//   A wr[g] in the same cycle req[g] falls is still forwarded.
//  GAP: exactly 1 cycle with no grant, so uart_tx sees the release; then go to IDLE.
//   Re-arbitration is therefore at least 2 cycles after release.
//  uart_din holds 0 whenever uart_wr=0.
//  drop_err pulses (registered, 1 cycle later) for any of:
//   - wr[i] without grant[i];
//   - wr[g] while uart_ready=0.
//   Dropped bytes are never queued.
//  Simultaneous requests resolve by the rr pointer only; lower index wins only relative to ptr.
//  A requester that holds req forever starves the others (by design) unless timeout is enabled.
//  NUM_REQ not a power of two: pointer wrap uses compare-with-(NUM_REQ-1), never a modulo of a wider counter.
//  Reset asserted mid-message: all state clears immediately; any uart_tx frame already in flight is uart_tx's concern.
// CONFIGURATION
//  `define UART_ARB_TIMEOUT_EN:
//   - an idle counter clears on every forwarded byte and counts in OWN;
//   - at TIMEOUT_CYCLES-1 it revokes the grant as if req had fallen (ptr advances, go to GAP) and pulses drop_err;
//   - the revoked requester must drop req before it can be granted again.
//  Without the macro: no counter is built; a grant is held until req falls; TIMEOUT_CYCLES is ignored.
// STRUCTURE
//  Package uart_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;
//   - localparam BYTE_W = 8.
//  Sub-module rr_pick #(N): combinational round-robin picker; inputs req and ptr; outputs idx and valid.
//  Everything else (FSM, mux, drop detect, timeout counter) lives in uart_tx_arbiter.
// TESTING
//  1. req=3'b001 with 4 bytes 0x41..0x44, uart_ready=1 -> grant=001 one cycle later; uart_din 0x41..0x44 in order; drop_err=0.
//  2. req=3'b111 held together, each sends 2 bytes then drops -> grant order 001, 010, 100; a GAP cycle with grant=0 between owners.
//  3. Requester 1 writes 0x55 while requester 0 is granted -> uart_wr shows only requester 0 bytes; drop_err pulses once.
//  4. Granted wr while uart_ready=0 -> uart_wr=0; drop_err=1 next cycle; the next write with uart_ready=1 goes through.
//  5. reset raised while in OWN with grant=010 -> grant, busy and uart_wr go to 0 immediately; after release, req=3'b011 is granted to 001 (ptr=0).
//  6. UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, grant held with no writes -> grant revoked at cycle 16; drop_err pulses; waiting req 2 is granted next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// Optional build macro: UART_ARB_TIMEOUT_EN (idle-grant revocation).
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      GAP
   } arb_state_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Wrap uses a compare against N-1 so non-power-of-two N never aliases.
module rr_pick #(
   parameter int N = 3,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         valid
);

   logic [W-1:0] pos;

   // Walk N positions cyclically from ptr, keep the first hit
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      pos   = ptr;
      for (int k = 0; k < N; k++) begin
         if (!valid && req[pos]) begin
            idx   = pos;
            valid = 1'b1;
         end
         pos = (pos == W'(N - 1)) ? '0 : pos + W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin owner of the single uart_tx byte port.
// Optional build macro: UART_ARB_TIMEOUT_EN revokes grants idle for TIMEOUT_CYCLES.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          wr,
   input  logic [BYTE_W*NUM_REQ-1:0]   din,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          ready,
   output logic                        uart_wr,
   output logic [BYTE_W-1:0]           uart_din,
   input  logic                        uart_ready,
   output logic                        busy,
   output logic                        drop_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   arb_state_t         state;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      next_ptr;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;
   logic [NUM_REQ-1:0] req_elig;
   logic [NUM_REQ-1:0] hit;
   logic               stray;
   logic               stall;
   logic               revoke;

   rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .req   (req_elig),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // grant is zero outside OWN, so masking wr with it gates by state too
   assign hit      = wr & grant;
   assign uart_wr  = (|hit) & uart_ready;
   assign ready    = grant & {NUM_REQ{uart_ready}};
   assign stray    = |(wr & ~grant);
   assign stall    = (|hit) & ~uart_ready;
   assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

   // Forward the owner's byte straight through; zero whenever no write
   always_comb begin
      uart_din = '0;
      if (uart_wr) begin
         uart_din = din[owner*BYTE_W +: BYTE_W];
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0]      idle_cnt;
   logic [NUM_REQ-1:0] blocked;

   assign revoke   = (state == OWN) && !uart_wr &&
                     (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign req_elig = req & ~blocked;

   // Idle counter for the held grant; a revoked requester stays
   // blocked until it lets go of req
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt <= '0;
         blocked  <= '0;
      end else begin
         if (state != OWN || uart_wr || revoke) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + CW'(1);
         end
         blocked <= (blocked & req) | (revoke ? grant : '0);
      end
   end
`else
   logic unused_timeout;

   // Timeout depth has no effect in this build
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign revoke         = 1'b0;
   assign req_elig       = req;
`endif

   // Ownership FSM: pick, hold until release, one empty cycle, re-pick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         owner <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant <= ONE << pick_idx;
                  busy  <= 1'b1;
                  owner <= pick_idx;
                  state <= OWN;
               end
            end
            OWN: begin
               if (!req[owner] || revoke) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= next_ptr;
                  state <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Discarded-write pulse, one cycle after the offending strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_err <= 1'b0;
      end else begin
         drop_err <= stray | stall | revoke;
      end
   end

endmodule
